ex_hazard_ctrl: RTL and testbench
=================================

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have parameter NB_REG, default 5, register-index width.
REQ-002 SHALL have ports: clk  in  1  pipeline clock, rising edge.
REQ-003 SHALL have ports: i_rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: i_valid_id  in  1  instruction present in ID.
REQ-005 SHALL have ports: i_id_rs, i_id_rt  in  NB_REG  source registers of the ID instruction.
REQ-006 SHALL have ports: i_id_uses_rs, i_id_uses_rt  in  1  operand actually read.
REQ-007 SHALL have ports: i_id_write_reg  in  NB_REG  resolved destination (rt/rd).
REQ-008 SHALL have ports: i_id_regWrite, i_id_memRead  in  1  ID control bits.
REQ-009 SHALL have ports: i_halt  in  1  ID instruction is HALT.
REQ-010 SHALL have ports: o_stall  out  1  hold PC and IF/ID.
REQ-011 SHALL have ports: o_bubble  out  1  load NOP into ID/EX.
REQ-012 SHALL have ports: o_fw_a, o_fw_b  out  2  EX operand selects: 00 regfile, 10 MEM/WB, 11 EX/MEM.
REQ-013 SHALL have ports: o_halted  out  1  pipeline drained after HALT.
REQ-014 SHALL have ports: o_state  out  2  FSM state, for debug.

Function
REQ-015 SHALL keep a shadow pipeline of slots EX, MEM and WB, each holding {valid, dest, regWrite, memRead}, all advancing every cycle.
REQ-016 SHALL load the EX slot from the ID inputs when i_valid_id=1 and o_bubble=0; otherwise it SHALL load an invalid entry.
REQ-017 SHALL treat a slot as a writer of register r only if valid, regWrite=1, dest==r and r!=0.
REQ-018 SHALL detect load-use when the EX slot is a writer with memRead=1 and matches rs (uses_rs) or rt (uses_rt).
REQ-019 SHALL drive o_stall=o_bubble=1 combinationally in the same cycle a hazard is detected; exactly one cycle per load-use.
REQ-020 SHALL compute o_fw_a/o_fw_b for the instruction entering EX and register them, so they are valid in the cycle that instruction occupies EX.
REQ-021 SHALL select 11 when the EX slot writes the operand, else 10 when the MEM slot writes it, else 00; EX/MEM has priority.
REQ-022 SHALL register 00 on any select whose operand is unused, whose register is r0, or whose entry is a bubble.
REQ-023 SHALL use FSM states RUN=0, DRAIN=1 and HALTED=2.
REQ-024 SHALL go from RUN to DRAIN on i_valid_id&i_halt with no hazard; when a hazard and HALT are simultaneous, the hazard is served first.
REQ-025 In DRAIN, SHALL hold o_stall=o_bubble=1, count 3 cycles, then enter HALTED.
REQ-026 In HALTED, SHALL hold o_halted=1 and o_stall=o_bubble=1 until reset, ignoring all inputs.
REQ-027 SHALL ignore i_halt outside RUN.

Reset
REQ-028 On clk edge with i_rst=1, SHALL set all slots invalid, o_fw_a=o_fw_b=00, o_halted=0, state RUN and drain counter 0.
REQ-029 While i_rst=1, SHALL hold o_stall=o_bubble=0.
REQ-030 Reset SHALL take priority over a DRAIN or HALTED state in progress.

Configuration
REQ-031 With EX_FORWARDING_EN defined, SHALL behave per REQ-018..022.
REQ-032 Without EX_FORWARDING_EN, SHALL force o_fw_a=o_fw_b=00.
REQ-033 Without EX_FORWARDING_EN, SHALL stall and bubble while the EX or MEM slot writes any used operand; WB needs no stall because the regfile writes before it reads.

Structure
REQ-034 SHALL take the FW_REGFILE/FW_MEMWB/FW_EXMEM codes, the state encodings, DRAIN_CYCLES=3 and REG_ZERO from shared package mips_pkg.
REQ-035 SHALL instantiate sub-module reg_match (slot vs. source compare, r0/valid/regWrite qualified) once per slot/operand pair.

Verification
REQ-036 lw $5 then add $6,$5,$2: SHALL give o_stall=o_bubble=1 for 1 cycle, then o_fw_a=10 when add is in EX.
REQ-037 add $3,$1,$1 then sub $4,$3,$3: SHALL give o_fw_a=o_fw_b=11 with no stall.
REQ-038 addi $0,.. then or $7,$0,$0: SHALL give o_fw_a=o_fw_b=00.
REQ-039 HALT: SHALL give o_state=1 for 3 cycles, then o_halted=1 held; i_rst=1 SHALL return o_state=0 and o_halted=0.
REQ-040 Same cycle as a load-use: SHALL serve the stall first, with DRAIN starting 1 cycle later.
REQ-041 Without EX_FORWARDING_EN, the REQ-037 sequence SHALL give 2 stall cycles and o_fw=00 throughout.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared pipeline constants: forwarding select codes, hazard FSM states, drain length.
// Optional build macro EX_FORWARDING_EN is consumed by ex_hazard_ctrl.
package mips_pkg;

  localparam logic [1:0] FW_REGFILE = 2'b00;
  localparam logic [1:0] FW_MEMWB   = 2'b10;
  localparam logic [1:0] FW_EXMEM   = 2'b11;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned REG_ZERO     = 0;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ID-stage request and hazard/forwarding response bundle of ex_hazard_ctrl.
// Macro EX_FORWARDING_EN does not affect this interface.
interface ex_hazard_ctrl_if #(
  parameter int unsigned NB_REG = 5
);
  logic              i_valid_id;
  logic [NB_REG-1:0] i_id_rs;
  logic [NB_REG-1:0] i_id_rt;
  logic              i_id_uses_rs;
  logic              i_id_uses_rt;
  logic [NB_REG-1:0] i_id_write_reg;
  logic              i_id_regWrite;
  logic              i_id_memRead;
  logic              i_halt;
  logic              o_stall;
  logic              o_bubble;
  logic [1:0]        o_fw_a;
  logic [1:0]        o_fw_b;
  logic              o_halted;
  logic [1:0]        o_state;

  modport master (
    output i_valid_id, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
    output i_id_write_reg, i_id_regWrite, i_id_memRead, i_halt,
    input  o_stall, o_bubble, o_fw_a, o_fw_b, o_halted, o_state
  );

  modport slave (
    input  i_valid_id, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
    input  i_id_write_reg, i_id_regWrite, i_id_memRead, i_halt,
    output o_stall, o_bubble, o_fw_a, o_fw_b, o_halted, o_state
  );

endinterface

// File: rtl/ex_hazard_ctrl_reg_match.sv
// True when a shadow-pipeline slot will write the given source register.
// r0 never matches. Unaffected by EX_FORWARDING_EN.
module reg_match
  import mips_pkg::*;
#(
  parameter int unsigned NB_REG = 5
) (
  input  logic              i_valid,
  input  logic              i_reg_write,
  input  logic [NB_REG-1:0] i_dest,
  input  logic [NB_REG-1:0] i_src,
  output logic              o_match
);

  always_comb begin
    o_match = i_valid & i_reg_write & (i_dest == i_src) & (i_src != NB_REG'(REG_ZERO));
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX hazard unit: load-use/RAW stalls, EX operand forwarding selects and HALT drain FSM.
// Define EX_FORWARDING_EN to forward from EX/MEM and MEM/WB; otherwise RAW hazards stall.
module ex_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned NB_REG = 5
) (
  input logic             clk,
  input logic             i_rst,
  ex_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [NB_REG-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  slot_t      ex_q, mem_q, wb_q, ex_d;
  logic [1:0] fw_a_q, fw_a_d, fw_b_q, fw_b_d;
  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       stall, hazard;

  // hit[slot][operand]: slot 0 = EX, 1 = MEM; operand 0 = rs, 1 = rt
  slot_t [1:0]             cmp_slot;
  logic  [1:0][NB_REG-1:0] cmp_src;
  logic  [1:0][1:0]        hit;
  logic  [1:0]             uses;

  assign cmp_slot = {mem_q, ex_q};
  assign cmp_src  = {bus.i_id_rt, bus.i_id_rs};
  assign uses     = {bus.i_id_uses_rt, bus.i_id_uses_rs};

  for (genvar s = 0; s < 2; s++) begin : g_slot
    for (genvar o = 0; o < 2; o++) begin : g_op
      reg_match #(
        .NB_REG (NB_REG)
      ) u_match (
        .i_valid     (cmp_slot[s].valid),
        .i_reg_write (cmp_slot[s].reg_write),
        .i_dest      (cmp_slot[s].dest),
        .i_src       (cmp_src[o]),
        .o_match     (hit[s][o])
      );
    end
  end

  // WB writes land in the regfile before ID reads, so its slot never causes a hazard.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  always_comb begin
    hazard = 1'b0;
`ifdef EX_FORWARDING_EN
    hazard = bus.i_valid_id & ex_q.mem_read & |(hit[0] & uses);
`else
    hazard = bus.i_valid_id & |((hit[0] | hit[1]) & uses);
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hazard) begin
          stall = 1'b1;
        end else if (bus.i_valid_id && bus.i_halt) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        stall = 1'b1;
        if (cnt_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = StHalted;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StHalted: stall = 1'b1;
      default:  state_d = StRun;
    endcase
    if (i_rst) begin
      stall = 1'b0;
    end
  end

  always_comb begin
    ex_d.valid     = bus.i_valid_id & ~stall;
    ex_d.dest      = bus.i_id_write_reg;
    ex_d.reg_write = bus.i_id_regWrite;
    ex_d.mem_read  = bus.i_id_memRead;
    fw_a_d         = FW_REGFILE;
    fw_b_d         = FW_REGFILE;
`ifdef EX_FORWARDING_EN
    if (ex_d.valid && uses[0]) begin
      fw_a_d = hit[0][0] ? FW_EXMEM : (hit[1][0] ? FW_MEMWB : FW_REGFILE);
    end
    if (ex_d.valid && uses[1]) begin
      fw_b_d = hit[0][1] ? FW_EXMEM : (hit[1][1] ? FW_MEMWB : FW_REGFILE);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fw_a_q  <= FW_REGFILE;
      fw_b_q  <= FW_REGFILE;
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fw_a_q  <= fw_a_d;
      fw_b_q  <= fw_b_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.o_stall  = stall;
    bus.o_bubble = stall;
    bus.o_fw_a   = fw_a_q;
    bus.o_fw_b   = fw_b_q;
    bus.o_halted = (state_q == StHalted);
    bus.o_state  = state_q;
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed, table-driven bench for ex_hazard_ctrl; expectations follow EX_FORWARDING_EN.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ex_hazard_ctrl;

  logic clk = 1'b0;
  logic i_rst;
  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.NB_REG(5)) bus ();

  ex_hazard_ctrl #(.NB_REG(5)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] wr;
    logic       rw;
    logic       mr;
    logic       halt;
  } instr_t;

  typedef struct packed {
    logic       rst;
    instr_t     in;
    logic       creg;   // also check the registered outputs on this row
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic instr_t ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                 input logic urt, input logic [4:0] wr, input logic rw,
                                 input logic mr, input logic halt);
    instr_t r;
    r = '{valid: 1'b1, rs: rs, rt: rt, urs: urs, urt: urt, wr: wr, rw: rw, mr: mr, halt: halt};
    return r;
  endfunction

  task automatic row(input logic rst, input instr_t in, input logic creg, input logic stall,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st);
    vec_t v;
    v = '{rst: rst, in: in, creg: creg, stall: stall, fa: fa, fb: fb, st: st};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input instr_t in);
    i_rst              = rst;
    bus.i_valid_id     = in.valid;
    bus.i_id_rs        = in.rs;
    bus.i_id_rt        = in.rt;
    bus.i_id_uses_rs   = in.urs;
    bus.i_id_uses_rt   = in.urt;
    bus.i_id_write_reg = in.wr;
    bus.i_id_regWrite  = in.rw;
    bus.i_id_memRead   = in.mr;
    bus.i_halt         = in.halt;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (row %0d): got %0d, expected %0d", name, idx, act, exp);
  endtask

  instr_t nop, add3, sub4, lw5, add6, addi0, or7, addi3, sub3a, hlt, hlt_ld, rnd;
  int     drain;
  logic   got;

  initial begin
    nop    = '0;
    add3   = ins(5'd1, 5'd1, 1, 1, 5'd3, 1, 0, 0);  // add  $3,$1,$1
    sub4   = ins(5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0);  // sub  $4,$3,$3
    lw5    = ins(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0);  // lw   $5,0($1)
    add6   = ins(5'd5, 5'd2, 1, 1, 5'd6, 1, 0, 0);  // add  $6,$5,$2
    addi0  = ins(5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0);  // addi $0,$1,imm
    or7    = ins(5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0);  // or   $7,$0,$0
    addi3  = ins(5'd1, 5'd0, 1, 0, 5'd3, 1, 0, 0);  // addi $3,$1,imm
    sub3a  = ins(5'd3, 5'd3, 1, 0, 5'd8, 1, 0, 0);  // reads rs=$3 only
    hlt    = ins(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    hlt_ld = ins(5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 1);  // HALT that also reads $5

    // RAW on ALU result
    row(1, nop, 0, 0, 2'b00, 2'b00, 0);
`ifdef EX_FORWARDING_EN
    row(0, add3, 1, 0, 2'b00, 2'b00, 0);
    row(0, sub4, 1, 0, 2'b00, 2'b00, 0);
    row(0, nop,  1, 0, 2'b11, 2'b11, 0);
    row(0, nop,  1, 0, 2'b00, 2'b00, 0);
`else
    row(0, add3, 1, 0, 2'b00, 2'b00, 0);
    row(0, sub4, 1, 1, 2'b00, 2'b00, 0);
    row(0, sub4, 1, 1, 2'b00, 2'b00, 0);
    row(0, sub4, 1, 0, 2'b00, 2'b00, 0);
    row(0, nop,  1, 0, 2'b00, 2'b00, 0);
`endif
    // load-use
    row(1, nop, 0, 0, 2'b00, 2'b00, 0);
`ifdef EX_FORWARDING_EN
    row(0, lw5,  1, 0, 2'b00, 2'b00, 0);
    row(0, add6, 1, 1, 2'b00, 2'b00, 0);
    row(0, add6, 1, 0, 2'b00, 2'b00, 0);
    row(0, nop,  1, 0, 2'b10, 2'b00, 0);
    row(0, nop,  1, 0, 2'b00, 2'b00, 0);
`else
    row(0, lw5,  1, 0, 2'b00, 2'b00, 0);
    row(0, add6, 1, 1, 2'b00, 2'b00, 0);
    row(0, add6, 1, 1, 2'b00, 2'b00, 0);
    row(0, add6, 1, 0, 2'b00, 2'b00, 0);
    row(0, nop,  1, 0, 2'b00, 2'b00, 0);
`endif
    // r0 is never forwarded nor stalled on
    row(1, nop,   0, 0, 2'b00, 2'b00, 0);
    row(0, addi0, 1, 0, 2'b00, 2'b00, 0);
    row(0, or7,   1, 0, 2'b00, 2'b00, 0);
    row(0, nop,   1, 0, 2'b00, 2'b00, 0);
    // EX/MEM priority over MEM/WB; unused rt gets 00
    row(1, nop, 0, 0, 2'b00, 2'b00, 0);
`ifdef EX_FORWARDING_EN
    row(0, add3,  1, 0, 2'b00, 2'b00, 0);
    row(0, addi3, 1, 0, 2'b00, 2'b00, 0);
    row(0, sub3a, 1, 0, 2'b00, 2'b00, 0);
    row(0, nop,   1, 0, 2'b11, 2'b00, 0);
    row(0, nop,   1, 0, 2'b00, 2'b00, 0);
`else
    row(0, add3,  1, 0, 2'b00, 2'b00, 0);
    row(0, addi3, 1, 0, 2'b00, 2'b00, 0);
    row(0, sub3a, 1, 1, 2'b00, 2'b00, 0);
    row(0, sub3a, 1, 1, 2'b00, 2'b00, 0);
    row(0, sub3a, 1, 0, 2'b00, 2'b00, 0);
    row(0, nop,   1, 0, 2'b00, 2'b00, 0);
`endif
    // HALT drain, inputs ignored after RUN, reset from HALTED
    row(1, nop,  0, 0, 2'b00, 2'b00, 0);
    row(0, hlt,  1, 0, 2'b00, 2'b00, 0);
    row(0, nop,  1, 1, 2'b00, 2'b00, 1);
    row(0, hlt,  1, 1, 2'b00, 2'b00, 1);
    row(0, nop,  1, 1, 2'b00, 2'b00, 1);
    row(0, nop,  1, 1, 2'b00, 2'b00, 2);
    row(0, add3, 1, 1, 2'b00, 2'b00, 2);
    row(1, hlt,  0, 0, 2'b00, 2'b00, 0);
    row(0, nop,  1, 0, 2'b00, 2'b00, 0);
    // reset in the middle of DRAIN
    row(0, hlt,  1, 0, 2'b00, 2'b00, 0);
    row(0, nop,  1, 1, 2'b00, 2'b00, 1);
    row(1, nop,  0, 0, 2'b00, 2'b00, 0);
    row(0, nop,  1, 0, 2'b00, 2'b00, 0);
    // load-use coinciding with HALT: stall first, DRAIN afterwards
    row(1, nop, 0, 0, 2'b00, 2'b00, 0);
`ifdef EX_FORWARDING_EN
    row(0, lw5,    1, 0, 2'b00, 2'b00, 0);
    row(0, hlt_ld, 1, 1, 2'b00, 2'b00, 0);
    row(0, hlt_ld, 1, 0, 2'b00, 2'b00, 0);
    row(0, nop,    1, 1, 2'b10, 2'b00, 1);
    row(0, nop,    1, 1, 2'b00, 2'b00, 1);
    row(0, nop,    1, 1, 2'b00, 2'b00, 1);
    row(0, nop,    1, 1, 2'b00, 2'b00, 2);
`else
    row(0, lw5,    1, 0, 2'b00, 2'b00, 0);
    row(0, hlt_ld, 1, 1, 2'b00, 2'b00, 0);
    row(0, hlt_ld, 1, 1, 2'b00, 2'b00, 0);
    row(0, hlt_ld, 1, 0, 2'b00, 2'b00, 0);
    row(0, nop,    1, 1, 2'b00, 2'b00, 1);
    row(0, nop,    1, 1, 2'b00, 2'b00, 1);
    row(0, nop,    1, 1, 2'b00, 2'b00, 1);
    row(0, nop,    1, 1, 2'b00, 2'b00, 2);
`endif

    drive(1, nop);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].in);
      #1;
      chk("stall",  i, {7'd0, bus.o_stall},  {7'd0, vecs[i].stall});
      chk("bubble", i, {7'd0, bus.o_bubble}, {7'd0, vecs[i].stall});
      if (vecs[i].creg) begin
        chk("fw_a",   i, {6'd0, bus.o_fw_a},   {6'd0, vecs[i].fa});
        chk("fw_b",   i, {6'd0, bus.o_fw_b},   {6'd0, vecs[i].fb});
        chk("state",  i, {6'd0, bus.o_state},  {6'd0, vecs[i].st});
        chk("halted", i, {7'd0, bus.o_halted}, {7'd0, (vecs[i].st == 2'd2)});
      end
    end

    // Hand sequence: measure drain length with a bounded wait, then hold and reset.
    @(negedge clk);
    drive(1, nop);
    @(negedge clk);
    drive(0, nop);
    #1;
    chk("rst_state",  -1, {6'd0, bus.o_state},  8'd0);
    chk("rst_halted", -1, {7'd0, bus.o_halted}, 8'd0);
    @(negedge clk);
    drive(0, hlt);
    @(negedge clk);
    drive(0, nop);
    drain = 0;
    got   = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (bus.o_halted === 1'b1) got = 1'b1;
      else begin
        if (bus.o_state === 2'd1) drain++;
        @(negedge clk);
      end
    end
    chk("halt_reached", -1, {7'd0, got}, 8'd1);
    chk("drain_len",    -1, 8'(drain),   8'd3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rnd = ins(5'($urandom), 5'($urandom), 1, 1, 5'($urandom), 1, 1'($urandom), 1);
      drive(0, rnd);
      #1;
      chk("hold_halted", k, {7'd0, bus.o_halted}, 8'd1);
      chk("hold_stall",  k, {7'd0, bus.o_stall},  8'd1);
    end
    @(negedge clk);
    drive(1, hlt);
    #1;
    chk("rst_stall", -1, {7'd0, bus.o_stall}, 8'd0);
    @(negedge clk);
    drive(0, nop);
    #1;
    chk("post_rst_state",  -1, {6'd0, bus.o_state},  8'd0);
    chk("post_rst_halted", -1, {7'd0, bus.o_halted}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
